// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state encoding, limits and round-robin helper for axis_arb_mux
package axis_arb_pkg;
  typedef enum logic [0:0] {IDLE, BUSY} state_t;
  localparam int MAX_INPUTS = 16;
  function automatic logic [3:0] rr_next(input logic [MAX_INPUTS-1:0] req, input logic [3:0] last, input int n);
    logic [3:0] idx;
    rr_next = last;
    // scan from farthest to nearest so the nearest requester after last wins
    for (int k = n; k >= 1; k--) begin
      idx = 4'((int'(last) + k) % n);
      if (req[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/axis_interface.sv
// axis_interface: AXI Stream bundle with Source/Sink modports
interface axis_interface #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic tvalid;
  logic tready;
  logic tlast;
  logic [ID_WIDTH-1:0] tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  modport Source(output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport Sink(input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_arb_rr_select.sv
// axis_arb_rr_select: combinational round-robin priority encoder starting after last
module axis_arb_rr_select
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_WIDTH = $clog2(NUM_INPUTS)
) (
  input logic [NUM_INPUTS-1:0] req,
  input logic [IDX_WIDTH-1:0] last,
  output logic any_req,
  output logic [IDX_WIDTH-1:0] next_idx
);
  assign any_req = |req;
  assign next_idx = IDX_WIDTH'(rr_next(MAX_INPUTS'(req), 4'(last), NUM_INPUTS));
endmodule

// File: rtl/axis_arb_mux.sv
// axis_arb_mux: packet-level round-robin AXI Stream arbiter/mux.
// Define AXIS_ARB_MUX_TID_TAG_EN to replace m_axis.tid with the grant index.
module axis_arb_mux
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  localparam int IDX_WIDTH = $clog2(NUM_INPUTS)
) (
  input logic clk,
  input logic reset,
  axis_interface.Sink s_axis [NUM_INPUTS],
  axis_interface.Source m_axis,
  output logic grant_valid,
  output logic [IDX_WIDTH-1:0] grant_index
);
  state_t state;
  logic [IDX_WIDTH-1:0] last_grant;
  logic [IDX_WIDTH-1:0] next_idx;
  logic any_req;
  logic [NUM_INPUTS-1:0] s_valid;
  logic [NUM_INPUTS-1:0] s_last;
  logic [DATA_WIDTH-1:0] s_data [NUM_INPUTS];
  logic [KEEP_WIDTH-1:0] s_keep [NUM_INPUTS];
  logic [ID_WIDTH-1:0] s_id [NUM_INPUTS];
  logic [DEST_WIDTH-1:0] s_dest [NUM_INPUTS];
  logic [USER_WIDTH-1:0] s_user [NUM_INPUTS];
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign s_valid[i] = s_axis[i].tvalid;
    assign s_last[i] = s_axis[i].tlast;
    assign s_data[i] = s_axis[i].tdata;
    assign s_keep[i] = s_axis[i].tkeep;
    assign s_id[i] = s_axis[i].tid;
    assign s_dest[i] = s_axis[i].tdest;
    assign s_user[i] = s_axis[i].tuser;
    assign s_axis[i].tready = grant_valid && grant_index == IDX_WIDTH'(i) && m_axis.tready;
  end
  axis_arb_rr_select #(.NUM_INPUTS(NUM_INPUTS), .IDX_WIDTH(IDX_WIDTH)) u_sel (
    .req(s_valid),
    .last(last_grant),
    .any_req(any_req),
    .next_idx(next_idx)
  );
  assign grant_valid = state == BUSY;
  assign m_axis.tvalid = grant_valid && s_valid[grant_index];
  assign m_axis.tlast = s_last[grant_index];
  assign m_axis.tdata = s_data[grant_index];
  assign m_axis.tkeep = s_keep[grant_index];
  assign m_axis.tdest = s_dest[grant_index];
  assign m_axis.tuser = s_user[grant_index];
`ifdef AXIS_ARB_MUX_TID_TAG_EN
  assign m_axis.tid = ID_WIDTH'(grant_index);
`else
  assign m_axis.tid = s_id[grant_index];
`endif
  // last_grant resets to the top index so input 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant_index <= '0;
      last_grant <= IDX_WIDTH'(NUM_INPUTS - 1);
    end else if (state == IDLE && any_req) begin
      grant_index <= next_idx;
      state <= BUSY;
    end else if (m_axis.tvalid && m_axis.tready && m_axis.tlast) begin
      last_grant <= grant_index;
      state <= IDLE;
    end
  end
endmodule
